// File: rtl/input_debounce.sv
// Button/switch input conditioning: 2-flop synchroniser plus per-bit
// stability-counter debounce, with one-cycle rising-edge pulses for buttons.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   btn_raw   raw button pins (async to clk)
//   sw_raw    raw switch pins (async to clk)
//   btn       debounced button levels (registered)
//   btn_rise  one-cycle pulse on a debounced button 0->1 transition
//   sw        conditioned switch levels (registered)
//
// Optional feature macro: INPUT_DEBOUNCE_SW_EN
//   defined   -> switches use the same debounce counter path as buttons
//   undefined -> switches are only synchronised (sw = s2)

module input_debounce #(
    parameter int DB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    input  logic [7:0] sw_raw,
    output logic [4:0] btn,
    output logic [4:0] btn_rise,
    output logic [7:0] sw
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

`ifdef INPUT_DEBOUNCE_SW_EN
    localparam int NDB = 13;
`else
    localparam int NDB = 5;
`endif

    // Bits 4:0 are buttons, 12:5 are switches.
    logic [12:0]    s1;
    logic [12:0]    s2;
    logic [NDB-1:0] db;
    logic [NDB-1:0] db_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {sw_raw, btn_raw};
            s2 <= s1;
        end
    end

    genvar i;
    for (i = 0; i < NDB; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             lvl_nxt;

        // Any cycle that agrees with the held level restarts the count.
        always_comb begin
            lvl_nxt = db[i];
            cnt_nxt = '0;
            if (s2[i] != db[i]) begin
                if (cnt == CNT_LAST) begin
                    lvl_nxt = s2[i];
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_nxt;
            end
        end

        assign db_nxt[i] = lvl_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db       <= '0;
            btn_rise <= '0;
        end else begin
            db       <= db_nxt;
            // Registered alongside db so the pulse coincides with btn rising.
            btn_rise <= db_nxt[4:0] & ~db[4:0];
        end
    end

    assign btn = db[4:0];

`ifdef INPUT_DEBOUNCE_SW_EN
    assign sw = db[12:5];
`else
    assign sw = s2[12:5];
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Scoreboard testbench for input_debounce: DB_CYCLES=4 main instance and
// DB_CYCLES=1 boundary instance, directed vectors with hand-computed results.

module tb_input_debounce;

`ifdef INPUT_DEBOUNCE_SW_EN
    localparam int SWL  = 6;
    localparam int SWLB = 3;
`else
    localparam int SWL  = 2;
    localparam int SWLB = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_raw_a, btn_a, rise_a;
    logic [7:0] sw_raw_a, sw_a;
    logic [4:0] btn_raw_b, btn_b, rise_b;
    logic [7:0] sw_raw_b, sw_b;

    always #5 clk = ~clk;

    input_debounce #(.DB_CYCLES(4)) u_a (
        .clk(clk), .rst(rst),
        .btn_raw(btn_raw_a), .sw_raw(sw_raw_a),
        .btn(btn_a), .btn_rise(rise_a), .sw(sw_a)
    );

    input_debounce #(.DB_CYCLES(1)) u_b (
        .clk(clk), .rst(rst),
        .btn_raw(btn_raw_b), .sw_raw(sw_raw_b),
        .btn(btn_b), .btn_rise(rise_b), .sw(sw_b)
    );

    typedef struct {
        int         cyc;
        int         dut;
        logic [4:0] bm;
        logic [4:0] be;
        logic [4:0] rm;
        logic [4:0] re;
        logic [7:0] sm;
        logic [7:0] se;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_at(
        input int c, input int d,
        input logic [4:0] bm, input logic [4:0] be,
        input logic [4:0] rm, input logic [4:0] re,
        input logic [7:0] sm, input logic [7:0] se,
        input string n
    );
        exp_t e;
        e.cyc = c; e.dut = d;
        e.bm = bm; e.be = be; e.rm = rm; e.re = re;
        e.sm = sm; e.se = se; e.name = n;
        q.push_back(e);
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        int         i;
        logic [4:0] b;
        logic [4:0] r;
        logic [7:0] s;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc == cyc) begin
                if (q[i].dut == 0) begin
                    b = btn_a; r = rise_a; s = sw_a;
                end else begin
                    b = btn_b; r = rise_b; s = sw_b;
                end
                checks++;
                if ((((b ^ q[i].be) & q[i].bm) != 0) ||
                    (((r ^ q[i].re) & q[i].rm) != 0) ||
                    (((s ^ q[i].se) & q[i].sm) != 0)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d btn=%h want %h/%h rise=%h want %h/%h sw=%h want %h/%h",
                             q[i].name, cyc, b, q[i].be, q[i].bm,
                             r, q[i].re, q[i].rm, s, q[i].se, q[i].sm);
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst       = 1'b0;
        btn_raw_a = 5'h1F;
        sw_raw_a  = 8'hFF;
        btn_raw_b = 5'h00;
        sw_raw_b  = 8'h00;

        // Reset with inputs high: outputs held at zero.
        tick(2);
        c = cyc;
        for (int k = 1; k <= 2; k++) begin
            expect_at(c + k, 0, 5'h1F, 0, 5'h1F, 0, 8'hFF, 0, "in_reset_a");
            expect_at(c + k, 1, 5'h1F, 0, 5'h1F, 0, 8'hFF, 0, "in_reset_b");
        end
        tick(3);
        rst = 1'b1;
        c = cyc;
        expect_at(c + 5, 0, 5'h1F, 5'h00, 5'h1F, 5'h00, 0, 0, "rel_pre");
        expect_at(c + 6, 0, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 0, 0, "rel_rise");
        expect_at(c + 7, 0, 5'h1F, 5'h1F, 5'h1F, 5'h00, 0, 0, "rel_post");
        expect_at(c + SWL - 1, 0, 0, 0, 0, 0, 8'hFF, 8'h00, "rel_sw_pre");
        expect_at(c + SWL, 0, 0, 0, 0, 0, 8'hFF, 8'hFF, "rel_sw");
        tick(8);
        btn_raw_a = 5'h00;
        sw_raw_a  = 8'h00;
        tick(10);

        // Clean press and release of button 2.
        btn_raw_a[2] = 1'b1;
        c = cyc;
        expect_at(c + 5, 0, 5'h1F, 5'h00, 5'h1F, 5'h00, 0, 0, "press_pre");
        expect_at(c + 6, 0, 5'h1F, 5'h04, 5'h1F, 5'h04, 0, 0, "press_rise");
        expect_at(c + 7, 0, 5'h1F, 5'h04, 5'h1F, 5'h00, 0, 0, "press_post");
        tick(10);
        btn_raw_a[2] = 1'b0;
        c = cyc;
        for (int k = 1; k <= 8; k++)
            expect_at(c + k, 0, 5'h1F, (k < 6) ? 5'h04 : 5'h00,
                      5'h1F, 5'h00, 0, 0, "release");
        tick(10);

        // Bounce on button 0, final stable 1 at c+4.
        c = cyc;
        for (int k = 1; k <= 9; k++)
            expect_at(c + k, 0, 5'h01, 0, 5'h01, 0, 0, 0, "bounce_low");
        expect_at(c + 10, 0, 5'h01, 5'h01, 5'h01, 5'h01, 0, 0, "bounce_rise");
        expect_at(c + 11, 0, 5'h01, 5'h01, 5'h01, 5'h00, 0, 0, "bounce_post");
        btn_raw_a[0] = 1'b1; tick(1);
        btn_raw_a[0] = 1'b0; tick(1);
        btn_raw_a[0] = 1'b1; tick(1);
        btn_raw_a[0] = 1'b0; tick(1);
        btn_raw_a[0] = 1'b1;
        tick(12);
        btn_raw_a[0] = 1'b0;
        tick(10);

        // Glitch one cycle shorter than the filter on button 1.
        c = cyc;
        for (int k = 1; k <= 10; k++)
            expect_at(c + k, 0, 5'h02, 0, 5'h02, 0, 0, 0, "glitch");
        btn_raw_a[1] = 1'b1;
        tick(3);
        btn_raw_a[1] = 1'b0;
        tick(10);

        // Async reset mid-count on button 3, button 4 already high.
        btn_raw_a[4] = 1'b1;
        sw_raw_a     = 8'h3C;
        tick(10);
        c = cyc;
        btn_raw_a[3] = 1'b1;
        expect_at(c + 3, 0, 5'h1F, 5'h10, 5'h1F, 0, 8'hFF, 8'h3C, "arst_pre");
        expect_at(c + 4, 0, 5'h1F, 5'h00, 5'h1F, 0, 8'hFF, 8'h00, "arst_clear");
        expect_at(c + 9, 0, 5'h1F, 5'h00, 5'h1F, 0, 0, 0, "arst_wait");
        expect_at(c + 10, 0, 5'h1F, 5'h18, 5'h1F, 5'h18, 0, 0, "arst_rise");
        expect_at(c + 11, 0, 5'h1F, 5'h18, 5'h1F, 5'h00, 0, 0, "arst_post");
        expect_at(c + 3 + SWL, 0, 0, 0, 0, 0, 8'hFF, 8'h00, "arst_sw_pre");
        expect_at(c + 4 + SWL, 0, 0, 0, 0, 0, 8'hFF, 8'h3C, "arst_sw");
        tick(4);
        rst = 1'b0;
        #7;
        rst = 1'b1;
        tick(10);

        // Switch path latency.
        c = cyc;
        sw_raw_a = 8'hA5;
        expect_at(c + SWL - 1, 0, 0, 0, 0, 0, 8'hFF, 8'h3C, "sw_pre");
        expect_at(c + SWL, 0, 0, 0, 0, 0, 8'hFF, 8'hA5, "sw_step");
        tick(10);

        // DB_CYCLES=1: three-flop delay, no filtering.
        c = cyc;
        btn_raw_b = 5'h1F;
        sw_raw_b  = 8'h5A;
        expect_at(c + 2, 1, 5'h1F, 5'h00, 5'h1F, 5'h00, 0, 0, "db1_pre");
        expect_at(c + 3, 1, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 0, 0, "db1_step");
        expect_at(c + 4, 1, 5'h1F, 5'h1F, 5'h1F, 5'h00, 0, 0, "db1_post");
        expect_at(c + SWLB - 1, 1, 0, 0, 0, 0, 8'hFF, 8'h00, "db1_sw_pre");
        expect_at(c + SWLB, 1, 0, 0, 0, 0, 8'hFF, 8'h5A, "db1_sw");
        tick(6);
        c = cyc;
        expect_at(c + 2, 1, 5'h1F, 5'h1F, 5'h1F, 5'h00, 0, 0, "db1_g_pre");
        expect_at(c + 3, 1, 5'h1F, 5'h1E, 5'h1F, 5'h00, 0, 0, "db1_g_low");
        expect_at(c + 4, 1, 5'h1F, 5'h1F, 5'h1F, 5'h01, 0, 0, "db1_g_rise");
        expect_at(c + 5, 1, 5'h1F, 5'h1F, 5'h1F, 5'h00, 0, 0, "db1_g_post");
        btn_raw_b = 5'h1E;
        tick(1);
        btn_raw_b = 5'h1F;
        tick(8);

        tick(2);
        if (q.size() != 0) begin
            $display("FAIL leftover expectations count=%0d want 0", q.size());
            errors += q.size();
            checks += q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
